// File: rtl/rgb_cmd_pkg.sv
// rgb_cmd_pkg: shared types and constants for the LED-colour command
// transmitter (rgb_cmd_tx) and its frame builder (rgb_cmd_frame).
//   tx_state_e  : transmitter FSM state (IDLE, SEND, ECHO)
//   ASCII_*     : frame byte values
//   ECHO_OFFSET : amount the remote board adds to every byte it echoes
//   COLOR_MAX   : highest legal colour code
package rgb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ECHO = 2'd2
  } tx_state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ECHO_OFFSET = 8'd3;
  localparam logic [2:0] COLOR_MAX   = 3'd6;

endpackage

// File: rtl/rgb_cmd_frame.sv
// rgb_cmd_frame: latches the colour of an accepted command and presents the
// frame byte selected by idx, plus a flag marking the last byte of the frame.
// Frame = ASCII digit, optionally followed by CR LF.
// Ports:
//   hw_clk, resetn : clock, asynchronous active-low reset
//   load           : capture color this cycle
//   color[2:0]     : colour code to capture (0-6)
//   idx[1:0]       : byte index within the frame
//   frame_byte[7:0]: byte at idx
//   frame_last     : idx addresses the final byte of the frame
module rgb_cmd_frame
  import rgb_cmd_pkg::*;
#(
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic       hw_clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [2:0] color,
  input  logic [1:0] idx,
  output logic [7:0] frame_byte,
  output logic       frame_last
);

  logic [2:0] color_q;

  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      color_q <= 3'd0;
    end else if (load) begin
      color_q <= color;
    end
  end

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      2'd0:    frame_byte = ASCII_ZERO + {5'd0, color_q};
      2'd1:    frame_byte = ASCII_CR;
      2'd2:    frame_byte = ASCII_LF;
      default: frame_byte = 8'h00;
    endcase
  end

  assign frame_last = APPEND_CRLF ? (idx == 2'd2) : (idx == 2'd0);

endmodule

// File: rtl/rgb_cmd_tx.sv
// rgb_cmd_tx: sends a colour command ('0'..'6' [+ CR LF]) through the register
// port of a simpleuart and, when RGB_CMD_TX_ECHO_CHECK_EN is defined, checks
// the remote board's echo (every byte + 3) with a per-byte timeout.
// Configuration macro: RGB_CMD_TX_ECHO_CHECK_EN (undefined: no echo check,
// echo_ok pulses right after the last byte is written, re/echo_err tied low).
// Ports:
//   hw_clk, resetn          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : command handshake; a command transfers on a
//                             cycle where both are high (ready only in IDLE,
//                             valid is ignored elsewhere, no queueing)
//   cmd_color[2:0]          : colour 0-6; 7 is rejected with a cmd_err pulse
//   cmd_err, busy           : illegal-colour pulse, FSM not in IDLE
//   reg_dat_we/di/wait      : UART write; a byte transfers when we && !wait
//   reg_dat_re/do           : UART read pop / read data (bit 31 = empty)
//   echo_ok, echo_err       : per-command result pulses
//   dbg_state[1:0]          : current FSM state
module rgb_cmd_tx
  import rgb_cmd_pkg::*;
#(
  parameter bit          APPEND_CRLF  = 1'b1,
  parameter logic [23:0] ECHO_TIMEOUT = 24'd120000
) (
  input  logic        hw_clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_color,
  output logic        cmd_ready,
  output logic        cmd_err,
  output logic        busy,
  output logic        reg_dat_we,
  output logic [31:0] reg_dat_di,
  input  logic        reg_dat_wait,
  output logic        reg_dat_re,
  input  logic [31:0] reg_dat_do,
  output logic        echo_ok,
  output logic        echo_err,
  output logic [1:0]  dbg_state
);

  tx_state_e  state;
  logic [1:0] idx;
  logic       frame_load;
  logic [7:0] frame_byte;
  logic       frame_last;

  assign frame_load = (state == IDLE) && cmd_valid && (cmd_color <= COLOR_MAX);

  rgb_cmd_frame #(
    .APPEND_CRLF (APPEND_CRLF)
  ) u_frame (
    .hw_clk     (hw_clk),
    .resetn     (resetn),
    .load       (frame_load),
    .color      (cmd_color),
    .idx        (idx),
    .frame_byte (frame_byte),
    .frame_last (frame_last)
  );

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign dbg_state  = state;
  // Data bus is zero whenever no write is offered, so it is 0 out of reset.
  assign reg_dat_di = reg_dat_we ? {24'd0, frame_byte} : 32'd0;

`ifdef RGB_CMD_TX_ECHO_CHECK_EN
  logic [23:0] echo_timer;
  logic [1:0]  echo_hold;   // cycles left to ignore reg_dat_do after a pop
  logic        echo_fail;
  logic        byte_bad;
  logic        unused_do;

  assign byte_bad  = (reg_dat_do[7:0] != (frame_byte + ECHO_OFFSET));
  assign unused_do = ^reg_dat_do[30:8];
`else
  logic unused_do;
  assign unused_do  = ^{reg_dat_do, ECHO_TIMEOUT};
  assign reg_dat_re = 1'b0;
  assign echo_err   = 1'b0;
`endif

  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= 2'd0;
      reg_dat_we <= 1'b0;
      cmd_err    <= 1'b0;
      echo_ok    <= 1'b0;
`ifdef RGB_CMD_TX_ECHO_CHECK_EN
      reg_dat_re <= 1'b0;
      echo_err   <= 1'b0;
      echo_timer <= 24'd0;
      echo_hold  <= 2'd0;
      echo_fail  <= 1'b0;
`endif
    end else begin
      cmd_err <= 1'b0;
      echo_ok <= 1'b0;
`ifdef RGB_CMD_TX_ECHO_CHECK_EN
      reg_dat_re <= 1'b0;
      echo_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_color > COLOR_MAX) begin
              cmd_err <= 1'b1;
            end else begin
              idx        <= 2'd0;
              reg_dat_we <= 1'b1;
              state      <= SEND;
            end
          end
        end

        SEND: begin
          if (reg_dat_we) begin
            if (!reg_dat_wait) begin
              // Byte taken: we stays low for one cycle before the next byte.
              reg_dat_we <= 1'b0;
              if (frame_last) begin
`ifdef RGB_CMD_TX_ECHO_CHECK_EN
                idx        <= 2'd0;
                echo_timer <= 24'd0;
                echo_hold  <= 2'd0;
                echo_fail  <= 1'b0;
                state      <= ECHO;
`else
                echo_ok <= 1'b1;
                state   <= IDLE;
`endif
              end else begin
                idx <= idx + 2'd1;
              end
            end
          end else begin
            reg_dat_we <= 1'b1;
          end
        end

`ifdef RGB_CMD_TX_ECHO_CHECK_EN
        ECHO: begin
          if (echo_hold != 2'd0) begin
            echo_hold <= echo_hold - 2'd1;
          end
          if ((echo_hold == 2'd0) && !reg_dat_do[31]) begin
            // Pop the byte; the UART needs a cycle to clear its valid flag,
            // so the following cycle's reg_dat_do is stale and skipped.
            reg_dat_re <= 1'b1;
            echo_hold  <= 2'd2;
            echo_timer <= 24'd0;
            if (frame_last) begin
              state <= IDLE;
              if (echo_fail || byte_bad) begin
                echo_err <= 1'b1;
              end else begin
                echo_ok <= 1'b1;
              end
            end else begin
              idx       <= idx + 2'd1;
              echo_fail <= echo_fail | byte_bad;
            end
          end else if (({1'b0, echo_timer} + 25'd1) >= {1'b0, ECHO_TIMEOUT}) begin
            // No reply in time: give up without touching the receive buffer.
            echo_err <= 1'b1;
            state    <= IDLE;
          end else if (echo_timer != 24'hFF_FFFF) begin
            echo_timer <= echo_timer + 24'd1;
          end
        end
`endif

        default: begin
          reg_dat_we <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_cmd_tx.sv
// tb_rgb_cmd_tx: directed test of rgb_cmd_tx against a small simpleuart model
// (fixed 5-cycle write wait, receive queue that returns all ones when empty).
// Expected UART writes and result pulses are queued by the driver and
// consumed by a monitor sampling on the falling clock edge.
module tb_rgb_cmd_tx;

  localparam int W          = 12;       // {tag[3:0], byte[7:0]}
  localparam int WAIT_CYC   = 5;
  localparam logic [3:0] T_WR     = 4'd1;
  localparam logic [3:0] T_RE     = 4'd2;
  localparam logic [3:0] T_OK     = 4'd3;
  localparam logic [3:0] T_ERR    = 4'd4;
  localparam logic [3:0] T_CMDERR = 4'd5;

  logic        hw_clk;
  logic        resetn;
  logic        cmd_valid;
  logic [2:0]  cmd_color;
  logic        cmd_ready;
  logic        cmd_err;
  logic        busy;
  logic        reg_dat_we;
  logic [31:0] reg_dat_di;
  logic        reg_dat_wait;
  logic        reg_dat_re;
  logic [31:0] reg_dat_do;
  logic        echo_ok;
  logic        echo_err;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  logic [7:0]   rx_q[$];
  int           wait_cnt;
  int           n_checks;
  int           n_fail;
  int           cyc;
  int           n_acc;
  int           last_acc_cyc;
  int           err_cyc;
  logic         prev_we;
  logic         prev_wait;
  logic         prev_acc;

  rgb_cmd_tx #(
    .APPEND_CRLF  (1'b1),
    .ECHO_TIMEOUT (24'd100)
  ) dut (
    .hw_clk       (hw_clk),
    .resetn       (resetn),
    .cmd_valid    (cmd_valid),
    .cmd_color    (cmd_color),
    .cmd_ready    (cmd_ready),
    .cmd_err      (cmd_err),
    .busy         (busy),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_wait (reg_dat_wait),
    .reg_dat_re   (reg_dat_re),
    .reg_dat_do   (reg_dat_do),
    .echo_ok      (echo_ok),
    .echo_err     (echo_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    hw_clk = 1'b0;
    forever #5 hw_clk = ~hw_clk;
  end

  // ---------------- UART model ----------------
  assign reg_dat_wait = (wait_cnt < WAIT_CYC);

  always @(posedge hw_clk) begin
    if (reg_dat_we) wait_cnt <= wait_cnt + 1;
    else            wait_cnt <= 0;
    if (reg_dat_re && rx_q.size() > 0) void'(rx_q.pop_front());
  end

  always @(negedge hw_clk) begin
    if (rx_q.size() > 0) reg_dat_do = {24'd0, rx_q[0]};
    else                 reg_dat_do = 32'hFFFF_FFFF;
  end

  // ---------------- scoreboard helpers ----------------
  function automatic logic [W-1:0] ev(input logic [3:0] tag, input logic [7:0] b);
    return {tag, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input string name, input logic [W-1:0] got);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event %h with empty queue (cycle %0d)", name, got, cyc);
    end else begin
      e = exp_q.pop_front();
      check(name, {20'd0, got}, {20'd0, e});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge hw_clk) begin
    cyc++;
    if (resetn) begin
      if (prev_we && prev_wait) check("we_held_while_wait", {31'd0, reg_dat_we}, 32'd1);
      if (prev_acc)             check("we_gap_after_accept", {31'd0, reg_dat_we}, 32'd0);
      if (reg_dat_we && !reg_dat_wait) begin
        n_acc++;
        last_acc_cyc = cyc;
        check("di_upper_zero", {8'd0, reg_dat_di[31:8]}, 32'd0);
        expect_ev("uart_write", ev(T_WR, reg_dat_di[7:0]));
      end
      if (reg_dat_re) expect_ev("rx_pop", ev(T_RE, 8'd0));
      if (echo_ok)    expect_ev("echo_ok", ev(T_OK, 8'd0));
      if (echo_err) begin
        err_cyc = cyc;
        expect_ev("echo_err", ev(T_ERR, 8'd0));
      end
      if (cmd_err)    expect_ev("cmd_err", ev(T_CMDERR, 8'd0));
      prev_we   = reg_dat_we;
      prev_wait = reg_dat_wait;
      prev_acc  = reg_dat_we && !reg_dat_wait;
    end else begin
      prev_we   = 1'b0;
      prev_wait = 1'b0;
      prev_acc  = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // mode (echo build only): 0 = correct echo, 1 = CR echo wrong, 2 = no reply
  task automatic send_cmd(input logic [2:0] color, input logic [7:0] digit,
                          input logic [7:0] echo_digit, input int mode);
    if (color == 3'd7) begin
      exp_q.push_back(ev(T_CMDERR, 8'd0));
    end else begin
      exp_q.push_back(ev(T_WR, digit));
      exp_q.push_back(ev(T_WR, 8'h0D));
      exp_q.push_back(ev(T_WR, 8'h0A));
`ifdef RGB_CMD_TX_ECHO_CHECK_EN
      if (mode == 2) begin
        exp_q.push_back(ev(T_ERR, 8'd0));
      end else begin
        rx_q.push_back(echo_digit);
        rx_q.push_back((mode == 1) ? 8'h11 : 8'h10);
        rx_q.push_back(8'h0D);
        repeat (3) exp_q.push_back(ev(T_RE, 8'd0));
        exp_q.push_back(ev((mode == 1) ? T_ERR : T_OK, 8'd0));
      end
`else
      exp_q.push_back(ev(T_OK, 8'd0));
`endif
    end
    @(negedge hw_clk);
    for (int i = 0; i < 500 && !cmd_ready; i++) @(negedge hw_clk);
    check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_color = color;
    @(negedge hw_clk);
    cmd_valid = 1'b0;
    if (color == 3'd7) begin
      check("illegal_ready_kept", {31'd0, cmd_ready}, 32'd1);
      check("illegal_no_we", {31'd0, reg_dat_we}, 32'd0);
    end else begin
      check("first_we_latency", {31'd0, reg_dat_we}, 32'd1);
      check("first_di", reg_dat_di, {24'd0, digit});
      check("busy_after_accept", {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || !cmd_ready); i++) @(negedge hw_clk);
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
    rx_q.delete();
    repeat (2) @(negedge hw_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    n_acc        = 0;
    last_acc_cyc = 0;
    err_cyc      = 0;
    wait_cnt     = 0;
    prev_we      = 1'b0;
    prev_wait    = 1'b0;
    prev_acc     = 1'b0;
    reg_dat_do   = 32'hFFFF_FFFF;
    resetn       = 1'b0;
    cmd_valid    = 1'b0;
    cmd_color    = 3'd0;

    repeat (3) @(negedge hw_clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_we", {31'd0, reg_dat_we}, 32'd0);
    check("rst_di", reg_dat_di, 32'd0);
    check("rst_re", {31'd0, reg_dat_re}, 32'd0);
    check("rst_pulses", {29'd0, echo_ok, echo_err, cmd_err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge hw_clk);

    // Colour 3, correct echo: '3' CR LF, echo '6' 0x10 0x0D
    send_cmd(3'd3, 8'h33, 8'h36, 0);
    wait_idle("drain_color3");

    // Colour 3, CR echoed as 0x11: error only after all three are drained
    send_cmd(3'd3, 8'h33, 8'h36, 1);
    wait_idle("drain_mismatch");

    // Colour 0 (lowest), correct echo
    send_cmd(3'd0, 8'h30, 8'h33, 0);
    wait_idle("drain_color0");

    // Colour 6 (highest legal), no reply
    send_cmd(3'd6, 8'h36, 8'h39, 2);
    wait_idle("drain_color6");
`ifdef RGB_CMD_TX_ECHO_CHECK_EN
    // error pulse occupies the cycle 100 edges after the last accepting edge
    check("timeout_latency", err_cyc - last_acc_cyc, 32'd101);
    check("timeout_ready_back", {31'd0, cmd_ready}, 32'd1);
`endif

    // Illegal colour
    send_cmd(3'd7, 8'h00, 8'h00, 0);
    wait_idle("drain_illegal");

    // Colour 5 with a stray request while busy (must be ignored)
    send_cmd(3'd5, 8'h35, 8'h38, 0);
    repeat (2) @(negedge hw_clk);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    check("ready_low_mid_frame", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1;
    cmd_color = 3'd1;
    @(negedge hw_clk);
    cmd_valid = 1'b0;
    wait_idle("drain_stray");

    // Back-to-back commands
    send_cmd(3'd1, 8'h31, 8'h34, 0);
    send_cmd(3'd2, 8'h32, 8'h35, 0);
    wait_idle("drain_b2b");

    // Reset during the second byte
    base = n_acc;
    send_cmd(3'd3, 8'h33, 8'h36, 2);
    for (int i = 0; i < 200 && !(n_acc == base + 1 && reg_dat_we); i++) @(negedge hw_clk);
    check("reached_second_byte", n_acc - base, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_we", {31'd0, reg_dat_we}, 32'd0);
    check("async_rst_re", {31'd0, reg_dat_re}, 32'd0);
    check("async_rst_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.delete();
    rx_q.delete();
    repeat (2) @(negedge hw_clk);
    resetn = 1'b1;
    @(negedge hw_clk);
    check("post_rst_state", {30'd0, dbg_state}, 32'd0);
    send_cmd(3'd3, 8'h33, 8'h36, 0);
    wait_idle("drain_after_reset");

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
